// File: rtl/fft_stage_tdm_if.sv
// Start/done handshake plus flattened sample, twiddle and result buses
// between one FFT stage and its neighbours.
interface fft_stage_tdm_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NPOINTS    = 32
);
    logic                                start;
    logic [NPOINTS*DATA_WIDTH-1:0]       in_real;
    logic [NPOINTS*DATA_WIDTH-1:0]       in_imag;
    logic [(NPOINTS/2)*DATA_WIDTH-1:0]   tw_real;
    logic [(NPOINTS/2)*DATA_WIDTH-1:0]   tw_imag;
    logic [NPOINTS*DATA_WIDTH-1:0]       out_real;
    logic [NPOINTS*DATA_WIDTH-1:0]       out_imag;
    logic                                busy;
    logic                                done;
    logic                                sat_flag;

    modport master (
        output start, in_real, in_imag, tw_real, tw_imag,
        input  out_real, out_imag, busy, done, sat_flag
    );

    modport slave (
        input  start, in_real, in_imag, tw_real, tw_imag,
        output out_real, out_imag, busy, done, sat_flag
    );
endinterface

// File: rtl/fft_stage_tdm.sv
// One radix-2 DIT FFT stage, time-multiplexed over NUM_BF butterflies:
// product registered in slot c, sums written to the outputs in slot c+1.
module fft_stage_tdm #(
    parameter int DATA_WIDTH = 8,
    parameter int FRACTION   = 4,
    parameter int NPOINTS    = 32,
    parameter int STAGE      = 2,
    parameter int NUM_BF     = 4,
    parameter int SCALE      = 0
) (
    input  logic           clk,
    input  logic           reset,
    fft_stage_tdm_if.slave bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int NB    = NPOINTS / 2;
    localparam int LOG2N = $clog2(NPOINTS);
    localparam int H     = 1 << (STAGE - 1);
    localparam int C     = NB / NUM_BF;
    localparam int CW    = (C > 1) ? $clog2(C) : 1;

    if ((NB % NUM_BF) != 0 || STAGE < 1 || STAGE > LOG2N || NPOINTS < 4 ||
        (NPOINTS & (NPOINTS - 1)) != 0) begin : g_param_error
        $error("fft_stage_tdm: NUM_BF must divide NPOINTS/2 and STAGE must be 1..log2(NPOINTS)");
    end

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [2*DW:0] wide_t;
    typedef logic [LOG2N-1:0]     idx_t;
    typedef logic [LOG2N-2:0]     tw_idx_t;
    typedef struct packed { sample_t v; logic sat; } clamp_t;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam wide_t MAX_V = wide_t'(2 ** (DW - 1) - 1);
    localparam wide_t MIN_V = wide_t'(-(2 ** (DW - 1)));

    function automatic wide_t sx(sample_t v);
        return wide_t'(v);
    endfunction

    function automatic clamp_t clamp(wide_t v);
        clamp_t r;
        if (v > MAX_V) begin
            r.v = sample_t'(MAX_V); r.sat = 1'b1;
        end else if (v < MIN_V) begin
            r.v = sample_t'(MIN_V); r.sat = 1'b1;
        end else begin
            r.v = sample_t'(v);     r.sat = 1'b0;
        end
        return r;
    endfunction

    // a*b -/+ c*d at full precision, back to Q format, then clamp.
    function automatic clamp_t prod(sample_t a, sample_t b, sample_t c, sample_t d, logic add);
        wide_t p = add ? (sx(a) * sx(b) + sx(c) * sx(d)) : (sx(a) * sx(b) - sx(c) * sx(d));
        return clamp(p >>> FRACTION);
    endfunction

    function automatic clamp_t bf_out(sample_t a, sample_t p, logic sub);
        wide_t s = sub ? (sx(a) - sx(p)) : (sx(a) + sx(p));
        if (SCALE != 0) s = s >>> 1;
        return clamp(s);
    endfunction

    function automatic idx_t top_idx(int b);
        return idx_t'(((b >> (STAGE - 1)) << STAGE) + (b & (H - 1)));
    endfunction

    function automatic tw_idx_t tw_idx(int b);
        return tw_idx_t'((b & (H - 1)) << (LOG2N - STAGE));
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sat_q, sat_d;
    sample_t         xr_q [NPOINTS], xr_d [NPOINTS];
    sample_t         xi_q [NPOINTS], xi_d [NPOINTS];
    sample_t         twr_q[NB],      twr_d[NB];
    sample_t         twi_q[NB],      twi_d[NB];
    sample_t         yr_q [NPOINTS], yr_d [NPOINTS];
    sample_t         yi_q [NPOINTS], yi_d [NPOINTS];
    sample_t         pr_q [NUM_BF],  pr_d [NUM_BF];
    sample_t         pi_q [NUM_BF],  pi_d [NUM_BF];
    logic            psat_q, psat_d;
    logic [CW-1:0]   pslot_q, pslot_d;
    logic            pvalid_q, pvalid_d;

    clamp_t p_re_c[NUM_BF], p_im_c[NUM_BF];
    clamp_t yt_re_c[NUM_BF], yt_im_c[NUM_BF], yb_re_c[NUM_BF], yb_im_c[NUM_BF];
    idx_t   dst_top_c[NUM_BF], dst_bot_c[NUM_BF];

    // Each lane issues from cnt_q and retires the slot held in pslot_q.
    for (genvar l = 0; l < NUM_BF; l++) begin : g_lane
        idx_t    src_bot;
        tw_idx_t k;
        assign src_bot      = top_idx(int'(cnt_q) * NUM_BF + l) + idx_t'(H);
        assign k            = tw_idx(int'(cnt_q) * NUM_BF + l);
        assign p_re_c[l]    = prod(twr_q[k], xr_q[src_bot], twi_q[k], xi_q[src_bot], 1'b0);
        assign p_im_c[l]    = prod(twr_q[k], xi_q[src_bot], twi_q[k], xr_q[src_bot], 1'b1);
        assign dst_top_c[l] = top_idx(int'(pslot_q) * NUM_BF + l);
        assign dst_bot_c[l] = dst_top_c[l] + idx_t'(H);
        assign yt_re_c[l]   = bf_out(xr_q[dst_top_c[l]], pr_q[l], 1'b0);
        assign yt_im_c[l]   = bf_out(xi_q[dst_top_c[l]], pi_q[l], 1'b0);
        assign yb_re_c[l]   = bf_out(xr_q[dst_top_c[l]], pr_q[l], 1'b1);
        assign yb_im_c[l]   = bf_out(xi_q[dst_top_c[l]], pi_q[l], 1'b1);
    end

    always_comb begin
        // NOTE: every _d takes its hold value first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sat_d    = sat_q;
        xr_d     = xr_q;
        xi_d     = xi_q;
        twr_d    = twr_q;
        twi_d    = twi_q;
        yr_d     = yr_q;
        yi_d     = yi_q;
        pr_d     = pr_q;
        pi_d     = pi_q;
        psat_d   = 1'b0;
        pslot_d  = pslot_q;
        pvalid_d = 1'b0;

        unique case (state_q)
            IDLE: if (bus.start) begin
                for (int i = 0; i < NPOINTS; i++) begin
                    xr_d[i] = bus.in_real[i*DW +: DW];
                    xi_d[i] = bus.in_imag[i*DW +: DW];
                end
                for (int i = 0; i < NB; i++) begin
                    twr_d[i] = bus.tw_real[i*DW +: DW];
                    twi_d[i] = bus.tw_imag[i*DW +: DW];
                end
                sat_d   = 1'b0;
                busy_d  = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                pvalid_d = 1'b1;
                pslot_d  = cnt_q;
                for (int l = 0; l < NUM_BF; l++) begin
                    pr_d[l] = p_re_c[l].v;
                    pi_d[l] = p_im_c[l].v;
                    psat_d  = psat_d | p_re_c[l].sat | p_im_c[l].sat;
                end
                if (cnt_q == CW'(C - 1)) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pvalid_q) begin
            sat_d = sat_d | psat_q;
            for (int l = 0; l < NUM_BF; l++) begin
                yr_d[dst_top_c[l]] = yt_re_c[l].v;
                yi_d[dst_top_c[l]] = yt_im_c[l].v;
                yr_d[dst_bot_c[l]] = yb_re_c[l].v;
                yi_d[dst_bot_c[l]] = yb_im_c[l].v;
                sat_d = sat_d | yt_re_c[l].sat | yt_im_c[l].sat | yb_re_c[l].sat | yb_im_c[l].sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            // NOTE: these arrays are plain registers rather than a memory, so they
            // take the synchronous clear and an aborted pass leaves nothing behind.
            xr_q     <= '{default: '0};
            xi_q     <= '{default: '0};
            twr_q    <= '{default: '0};
            twi_q    <= '{default: '0};
            yr_q     <= '{default: '0};
            yi_q     <= '{default: '0};
            pr_q     <= '{default: '0};
            pi_q     <= '{default: '0};
            psat_q   <= 1'b0;
            pslot_q  <= '0;
            pvalid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples its peers' pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
            xr_q     <= xr_d;
            xi_q     <= xi_d;
            twr_q    <= twr_d;
            twi_q    <= twi_d;
            yr_q     <= yr_d;
            yi_q     <= yi_d;
            pr_q     <= pr_d;
            pi_q     <= pi_d;
            psat_q   <= psat_d;
            pslot_q  <= pslot_d;
            pvalid_q <= pvalid_d;
        end
    end

    always_comb begin
        bus.out_real = '0;
        bus.out_imag = '0;
        for (int i = 0; i < NPOINTS; i++) begin
            bus.out_real[i*DW +: DW] = yr_q[i];
            bus.out_imag[i*DW +: DW] = yi_q[i];
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sat_flag = sat_q;
endmodule

// File: doc/fft_stage_tdm.md
Name: fft_stage_tdm

Overview:
- Parametrised, time-multiplexed radix-2 DIT FFT stage. Replaces the fixed per-stage blocks that used one butterfly per pair and two hard-wired twiddles.
- Any stage STAGE of an NPOINTS-point FFT runs on NUM_BF physical butterflies.
- Sits between the previous stage's output vector and the next stage. Connection is a start/done handshake; data moves as flattened parallel buses.
- Adds optional per-stage 1/2 scaling and a sticky saturation flag.

Parameters:
- DATA_WIDTH, 8: signed two's-complement width of each real/imag component.
- FRACTION, 4: fractional bits (Q(DATA_WIDTH-FRACTION).FRACTION).
- NPOINTS, 32: FFT size, power of two, ≥4.
- STAGE, 2: stage index, 1..log2(NPOINTS); butterfly span H = 2^(STAGE-1).
- NUM_BF, 4: physical butterflies, power of two, divides NPOINTS/2.
- SCALE, 0: 1 = arithmetic shift right by 1 on every butterfly output (truncate toward -inf).

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- start, in, 1: begin a pass; honoured only in IDLE.
- in_real, in, NPOINTS*DATA_WIDTH: input samples; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_imag, in, NPOINTS*DATA_WIDTH: imaginary parts, same packing.
- tw_real, in, (NPOINTS/2)*DATA_WIDTH: twiddle table, entry k = Re(W_N^k).
- tw_imag, in, (NPOINTS/2)*DATA_WIDTH: Im(W_N^k).
- out_real, out, NPOINTS*DATA_WIDTH: stage results, registered, same packing.
- out_imag, out, NPOINTS*DATA_WIDTH: stage results, imaginary parts.
- busy, out, 1: pass in progress.
- done, out, 1: one-cycle pulse, all outputs final.
- sat_flag, out, 1: sticky, any saturation during the current or last pass.

Behaviour:
- Reset:
  - state IDLE; out_real/out_imag all 0; busy 0, done 0, sat_flag 0.
  - Input snapshot and pipeline registers cleared.
  - Reset mid-pass aborts the pass immediately; no partial results are kept.
- Butterfly indexing, for b in 0..NPOINTS/2-1:
  - g = b/H, j = b mod H.
  - top = g*2H + j, bot = top + H.
  - twiddle index k = j*(NPOINTS/(2H)).
- Butterfly math:
  - P = W_k * x[bot]: full 2*DATA_WIDTH products, sum/difference, then arithmetic shift right by FRACTION, then saturate to DATA_WIDTH.
  - y[top] = x[top] + P; y[bot] = x[top] - P.
  - Sums computed at DATA_WIDTH+1 bits. If SCALE, shift right 1 first; then saturate to [-2^(DW-1), 2^(DW-1)-1].
  - Any clamp (product or sum) sets sat_flag.
- Schedule: C = NPOINTS/(2*NUM_BF) issue cycles. Issue slot c handles butterflies b = c*NUM_BF .. c*NUM_BF+NUM_BF-1.
- FSM:
  - IDLE: on start at edge E0, capture in_real/in_imag/tw into snapshot registers, clear sat_flag, set busy, go to RUN with cnt=0. Inputs may change after E0.
  - RUN: edges E1..EC, one slot per edge; the product of slot c is registered (pipeline stage 1). Edges E2..E(C+1) write the butterfly results of slot c-1 into out_real/out_imag. At EC, cnt wraps and the state goes to FLUSH.
  - FLUSH: at edge E(C+1), last slot written, done=1, busy=0, state goes to IDLE.
- Latency: done is high in cycle E(C+1)..E(C+2), i.e. C+1 cycles after start is sampled. Minimum start-to-start spacing is C+1 cycles.
- start while busy is ignored; no queueing.
- start in the same cycle that done is high is sampled at E(C+2) and accepted (state is already IDLE).
- Outputs not yet written in the current pass hold the previous pass values until overwritten. Consumers use only done.
- done is never high for more than one cycle. sat_flag holds until the next accepted start or reset.
- Elaboration error if NUM_BF does not divide NPOINTS/2 or STAGE is out of range.

Test Plan:
- Defaults (N=32, STAGE=2, NUM_BF=4, C=4); all inputs real 0x10, imag 0; tw[0]=(0x10,0), tw[8]=(0x00,0xF0); start → done pulses exactly 5 cycles after start; out[0]=(0x20,0x00), out[2]=(0,0), out[1]=(0x10,0xF0), out[3]=(0x10,0x10); sat_flag=0.
- Saturation: in[0]=in[2]=(0x70,0) → out[0]=(0x7F,0), out[2]=(0,0), sat_flag=1; next start with all-small inputs → sat_flag cleared to 0.
- SCALE=1, same stimulus as test 1 → out[0]=(0x10,0), out[1]=(0x08,0xF8), out[3]=(0x08,0x08).
- start pulsed again during busy and in the done cycle → the busy pulse is ignored (single done); the done-cycle start is accepted and the next done comes 5 cycles later.
- reset asserted in RUN cycle 2 → next cycle all outputs 0, busy=0, and no done pulse follows.
- Sweep STAGE=1..5 and NUM_BF=1,16 against a software model using random inputs: bit-exact outputs; done latency = N/(2*NUM_BF)+1.
